// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit/receive blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_tx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } uart_parity_t;

    // Per-frame line settings, captured together when a word is popped.
    typedef struct packed {
        uart_parity_t parity;
        logic         two_stop;
    } uart_tx_cfg_t;

    localparam int unsigned MIN_DATA_BITS      = 5;
    localparam int unsigned MAX_DATA_BITS      = 9;
    localparam int unsigned MIN_CYCLES_PER_BIT = 4;

    function automatic int unsigned cycles_per_bit(input int unsigned freq,
                                                   input int unsigned baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-period timer: bit_end is high on the last clock of every bit period.
// Shared between the transmitter and the future receiver.
module uart_baud_timer #(
    parameter int unsigned CYCLES_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_end
);

    localparam int unsigned CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;

    logic [CW-1:0] count;

    // bit_end mirrors count == CYCLES_PER_BIT-1, so it doubles as the wrap condition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            bit_end <= 1'b0;
        end else if (clear || bit_end) begin
            count   <= '0;
            bit_end <= 1'b0;
        end else begin
            count   <= count + CW'(1);
            bit_end <= (count == CW'(CYCLES_PER_BIT - 2));
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: pops a show-ahead FIFO and serialises start/data/parity/stop.
// Define UART_TX_BREAK_EN to add the break_req input and the line-break state.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] fifo_data,
    input  logic                 fifo_empty,
    output logic                 fifo_read,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_two_stop,
`ifdef UART_TX_BREAK_EN
    input  logic                 break_req,
`endif
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int unsigned CYCLES_PER_BIT = cycles_per_bit(CLOCK_FREQ, BAUD);
    localparam int unsigned IDX_W          = 4;

    if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be within 5..9");
    end
    if (CYCLES_PER_BIT < MIN_CYCLES_PER_BIT) begin : g_bad_rate
        $error("uart_tx_frame: CLOCK_FREQ/BAUD must be at least 4");
    end

    uart_tx_state_t       state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    uart_tx_cfg_t         cfg_q, cfg_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 run_q;
    logic                 tx_d, busy_d, frame_done_d;
    logic                 timer_clear, bit_end;
`ifdef UART_TX_BREAK_EN
    localparam int unsigned BRK_BITS = DATA_BITS + 3;
    logic [IDX_W-1:0]     brk_cnt_q, brk_cnt_d;
    logic                 brk_q, brk_d;
`endif

    uart_baud_timer #(
        .CYCLES_PER_BIT(CYCLES_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .bit_end(bit_end)
    );

    // Next-state, datapath and output decode.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        data_d       = data_q;
        cfg_d        = cfg_q;
        bit_idx_d    = bit_idx_q;
        stop_cnt_d   = stop_cnt_q;
        fifo_read    = 1'b0;
        frame_done_d = 1'b0;
        timer_clear  = (state_q == IDLE);
`ifdef UART_TX_BREAK_EN
        brk_cnt_d    = brk_cnt_q;
        brk_d        = brk_q;
`endif

        case (state_q)
            IDLE: begin
`ifdef UART_TX_BREAK_EN
                if (run_q && break_req) begin
                    state_d         = BREAK;
                    brk_cnt_d       = '0;
                    brk_d           = 1'b1;
                    stop_cnt_d      = 1'b0;
                    cfg_d.two_stop  = 1'b0;
                end else
`endif
                if (run_q && !fifo_empty) begin
                    fifo_read      = 1'b1;
                    shift_d        = fifo_data;
                    data_d         = fifo_data;
                    cfg_d.parity   = (cfg_parity == 2'b11) ? PAR_NONE : uart_parity_t'(cfg_parity);
                    cfg_d.two_stop = cfg_two_stop;
                    bit_idx_d      = '0;
                    stop_cnt_d     = 1'b0;
                    state_d        = START;
`ifdef UART_TX_BREAK_EN
                    brk_d          = 1'b0;
`endif
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                        bit_idx_d = '0;
                        state_d   = (cfg_q.parity == PAR_NONE) ? STOP : PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (cfg_q.two_stop && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b0;
                        state_d    = IDLE;
`ifdef UART_TX_BREAK_EN
                        frame_done_d = !brk_q;
`else
                        frame_done_d = 1'b1;
`endif
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            // Hold the line low for at least BRK_BITS bit times, then one stop bit.
            BREAK: begin
                if (bit_end) begin
                    if (brk_cnt_q < IDX_W'(BRK_BITS - 1)) begin
                        brk_cnt_d = brk_cnt_q + IDX_W'(1);
                    end else if (!break_req) begin
                        state_d = STOP;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);

        // tx is computed from the next state so the line lines up with the registered state.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = (^data_q) ^ (cfg_q.parity == PAR_ODD);
            BREAK:   tx_d = 1'b0;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            data_q     <= '0;
            cfg_q      <= '{parity: PAR_NONE, two_stop: 1'b0};
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            run_q      <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            cfg_q      <= cfg_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            run_q      <= 1'b1;
            tx         <= tx_d;
            busy       <= busy_d;
            frame_done <= frame_done_d;
        end
    end

`ifdef UART_TX_BREAK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brk_cnt_q <= '0;
            brk_q     <= 1'b0;
        end else begin
            brk_cnt_q <= brk_cnt_d;
            brk_q     <= brk_d;
        end
    end
`endif

endmodule
